// File: rtl/dual_port_bank_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dual_port_mem_pkg
// Shared definitions for the dual-port banked memory access controller.
//   BANK_BITS     : number of upper address bits that select a bank
//   ADDR_PER_BANK : number of lower address bits that index within a bank
//   bank_of()     : extracts the bank field from a word address
//   prio_e        : which port wins a same-address collision
// The geometry constants describe the default memory configuration.
// ---------------------------------------------------------------------------
package dual_port_mem_pkg;

   localparam int NUM_BANK_DEF   = 4;
   localparam int ADDR_TOTAL_DEF = 10;
   localparam int BANK_BITS      = $clog2(NUM_BANK_DEF);
   localparam int ADDR_PER_BANK  = ADDR_TOTAL_DEF - BANK_BITS;

   typedef enum logic {
      PRIO_A = 1'b0,
      PRIO_B = 1'b1
   } prio_e;

   function automatic logic [BANK_BITS-1:0] bank_of(input logic [ADDR_TOTAL_DEF-1:0] addr);
      return addr[ADDR_TOTAL_DEF-1 -: BANK_BITS];
   endfunction

endpackage

// File: rtl/dual_port_bank_access_ctrl_rd_rsp_pipe.sv
// ---------------------------------------------------------------------------
// rd_rsp_pipe
// Per-port read-response valid tracker. A 1 is pushed for each memory read
// cycle and emerges RD_LAT cycles later, lining up with valid memory data.
// Ports:
//   i_clk   : clock
//   i_rst_n : synchronous active-low reset; flushes all in-flight reads
//   i_push  : memory read issued this cycle
//   o_vld   : memory read data is valid this cycle
// ---------------------------------------------------------------------------
module rd_rsp_pipe #(
   parameter int RD_LAT = 1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_push,
   output logic o_vld
);

   logic [RD_LAT-1:0] vld_sr;

   // Shift form works for any RD_LAT >= 1 without a zero-width slice.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         vld_sr <= '0;
      end else begin
         vld_sr <= (vld_sr << 1) | RD_LAT'(i_push);
      end
   end

   assign o_vld = vld_sr[RD_LAT-1];

endmodule

// File: rtl/dual_port_bank_access_ctrl.sv
// ---------------------------------------------------------------------------
// dual_port_bank_access_ctrl
// Drives both ports of a dual-port banked memory from two independent
// valid/ready request streams. Same-address collisions involving a write
// are arbitrated round-robin; read data is returned as response pulses.
// Ports:
//   i_clk, i_rst_n                  : clock, synchronous active-low reset
//   i_req_valid_x / o_req_ready_x   : request handshake per port (x = a, b)
//   i_req_we_x, i_req_addr_x,
//   i_req_wdata_x                   : request write-enable, address, data
//   o_rsp_valid_x, o_rsp_rdata_x    : read response pulse and data
//   o_mem_en_x, o_mem_we_x,
//   o_mem_addr_x, o_mem_din_x       : registered memory port controls
//   i_mem_dout_x                    : memory read data
//   o_conflict_cnt                  : saturating count of collision cycles
// ---------------------------------------------------------------------------
module dual_port_bank_access_ctrl
   import dual_port_mem_pkg::*;
#(
   parameter int WIDTH      = 12,
   parameter int ADDR_TOTAL = 10,
   parameter int NUM_BANK   = 4,
   parameter int RD_LAT     = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_req_valid_a,
   input  logic                  i_req_valid_b,
   output logic                  o_req_ready_a,
   output logic                  o_req_ready_b,
   input  logic                  i_req_we_a,
   input  logic                  i_req_we_b,
   input  logic [ADDR_TOTAL-1:0] i_req_addr_a,
   input  logic [ADDR_TOTAL-1:0] i_req_addr_b,
   input  logic [WIDTH-1:0]      i_req_wdata_a,
   input  logic [WIDTH-1:0]      i_req_wdata_b,
   output logic                  o_rsp_valid_a,
   output logic                  o_rsp_valid_b,
   output logic [WIDTH-1:0]      o_rsp_rdata_a,
   output logic [WIDTH-1:0]      o_rsp_rdata_b,
   output logic                  o_mem_en_a,
   output logic                  o_mem_en_b,
   output logic                  o_mem_we_a,
   output logic                  o_mem_we_b,
   output logic [ADDR_TOTAL-1:0] o_mem_addr_a,
   output logic [ADDR_TOTAL-1:0] o_mem_addr_b,
   output logic [WIDTH-1:0]      o_mem_din_a,
   output logic [WIDTH-1:0]      o_mem_din_b,
   input  logic [WIDTH-1:0]      i_mem_dout_a,
   input  logic [WIDTH-1:0]      i_mem_dout_b,
   output logic [15:0]           o_conflict_cnt
);

   localparam int BANK_W = $clog2(NUM_BANK);
   localparam int OFF_W  = ADDR_TOTAL - BANK_W;

   prio_e                 prio;
   logic                  same_bank;
   logic                  same_off;
   logic                  collision;
   logic                  acc_a;
   logic                  acc_b;
   logic                  mem_en_a_p1;
   logic                  mem_en_b_p1;
   logic                  mem_we_a_p1;
   logic                  mem_we_b_p1;
   logic [ADDR_TOTAL-1:0] mem_addr_a_p1;
   logic [ADDR_TOTAL-1:0] mem_addr_b_p1;
   logic [WIDTH-1:0]      mem_din_a_p1;
   logic [WIDTH-1:0]      mem_din_b_p1;
   logic [15:0]           conflict_cnt;
   logic                  rsp_vld_a;
   logic                  rsp_vld_b;

   // Bank and in-bank offset compared separately; together they form the
   // full word address.
   assign same_bank = (i_req_addr_a[ADDR_TOTAL-1 -: BANK_W] == i_req_addr_b[ADDR_TOTAL-1 -: BANK_W]);
   assign same_off  = (i_req_addr_a[OFF_W-1:0] == i_req_addr_b[OFF_W-1:0]);

   // Read-read to one address is harmless on a true dual-port memory.
   assign collision = i_req_valid_a & i_req_valid_b & same_bank & same_off
                    & (i_req_we_a | i_req_we_b);

   // Ready is held low during reset so nothing is accepted.
   assign o_req_ready_a = i_rst_n & (~collision | (prio == PRIO_A));
   assign o_req_ready_b = i_rst_n & (~collision | (prio == PRIO_B));

   assign acc_a = i_req_valid_a & o_req_ready_a;
   assign acc_b = i_req_valid_b & o_req_ready_b;

   // Issue stage: accepted requests land on the memory port one cycle later.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         prio          <= PRIO_A;
         conflict_cnt  <= '0;
         mem_en_a_p1   <= 1'b0;
         mem_en_b_p1   <= 1'b0;
         mem_we_a_p1   <= 1'b0;
         mem_we_b_p1   <= 1'b0;
         mem_addr_a_p1 <= '0;
         mem_addr_b_p1 <= '0;
         mem_din_a_p1  <= '0;
         mem_din_b_p1  <= '0;
      end else begin
         // Priority passes to the loser so neither port can starve.
         if (collision) begin
            if (prio == PRIO_A) begin
               prio <= PRIO_B;
            end else begin
               prio <= PRIO_A;
            end
            if (conflict_cnt != 16'hFFFF) begin
               conflict_cnt <= conflict_cnt + 16'd1;
            end
         end
         mem_en_a_p1 <= acc_a;
         mem_en_b_p1 <= acc_b;
         mem_we_a_p1 <= acc_a & i_req_we_a;
         mem_we_b_p1 <= acc_b & i_req_we_b;
         if (acc_a) begin
            mem_addr_a_p1 <= i_req_addr_a;
            mem_din_a_p1  <= i_req_wdata_a;
         end
         if (acc_b) begin
            mem_addr_b_p1 <= i_req_addr_b;
            mem_din_b_p1  <= i_req_wdata_b;
         end
      end
   end

   assign o_mem_en_a     = mem_en_a_p1;
   assign o_mem_en_b     = mem_en_b_p1;
   assign o_mem_we_a     = mem_we_a_p1;
   assign o_mem_we_b     = mem_we_b_p1;
   assign o_mem_addr_a   = mem_addr_a_p1;
   assign o_mem_addr_b   = mem_addr_b_p1;
   assign o_mem_din_a    = mem_din_a_p1;
   assign o_mem_din_b    = mem_din_b_p1;
   assign o_conflict_cnt = conflict_cnt;

   // Response stage: track reads from the memory-enable cycle for RD_LAT cycles.
   rd_rsp_pipe #(.RD_LAT(RD_LAT)) u_rsp_a (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (mem_en_a_p1 & ~mem_we_a_p1),
      .o_vld   (rsp_vld_a)
   );

   rd_rsp_pipe #(.RD_LAT(RD_LAT)) u_rsp_b (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (mem_en_b_p1 & ~mem_we_b_p1),
      .o_vld   (rsp_vld_b)
   );

   // Data is passed straight through from the memory and forced to zero
   // outside a response so the bus is quiet when idle or in reset.
   assign o_rsp_valid_a = rsp_vld_a;
   assign o_rsp_valid_b = rsp_vld_b;
   assign o_rsp_rdata_a = rsp_vld_a ? i_mem_dout_a : '0;
   assign o_rsp_rdata_b = rsp_vld_b ? i_mem_dout_b : '0;

endmodule
